// File: rtl/seq_detect_ctrl.sv
// Run-time controller for the serial Mealy pattern detector: programmable pattern/len/overlap/target, IDLE/RUN/DONE sequencing.
// Latency: z is combinational on x; busy, done, match_cnt, cnt_sat and cfg_err update one clk edge after the cause.
// No backpressure: x is consumed on every x_valid cycle in RUN. SEQ_DETECT_TIMEOUT_EN adds a RUN no-match timeout.
module seq_detect_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_wr,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    input  logic [CNT_W-1:0]             cfg_target,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         x,
    input  logic                         x_valid,
    output logic                         z,
    output logic                         busy,
    output logic                         done,
    output logic [CNT_W-1:0]             match_cnt,
    output logic                         cnt_sat,
    output logic                         cfg_err
`ifdef SEQ_DETECT_TIMEOUT_EN
    ,
    output logic                         timeout
`endif
);
    localparam int LW = $clog2(MAX_LEN+1);
    localparam int FW = $clog2(MAX_LEN);
    localparam logic [FW-1:0] FILL_MAX = FW'(MAX_LEN-1);

    if (MAX_LEN < 2 || MAX_LEN > 16 || TIMEOUT < 1) begin : g_param_check
        $error("seq_detect_ctrl: MAX_LEN must be 2..16 and TIMEOUT at least 1");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [MAX_LEN-1:0] pattern_q;
    logic [LW-1:0]      len_q;
    logic               overlap_q;
    logic [CNT_W-1:0]   target_q;
    logic [MAX_LEN-2:0] history;
    logic [FW-1:0]      fill;

    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic [CNT_W-1:0]   cnt_inc;
    logic               len_ok;
    logic               fill_ok;
    logic               hit;
    logic               target_hit;
    logic               timeout_hit;
    logic               arm;
    logic               cfg_load;
    logic               cfg_err_nxt;

    // Only the low len bits of window and pattern take part in the compare.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LW'(i) < len_q);
        end
    end

    assign window     = {history, x};
    assign len_ok     = (len_q >= LW'(2)) && (len_q <= LW'(MAX_LEN));
    assign fill_ok    = (LW'(fill) >= (len_q - LW'(1)));
    assign hit        = ((window & mask) == (pattern_q & mask));
    assign z          = rst && (state == RUN) && x_valid && fill_ok && hit;
    assign cnt_inc    = (&match_cnt) ? match_cnt : match_cnt + CNT_W'(1);
    assign target_hit = (target_q != '0) && (cnt_inc == target_q);
    assign busy       = (state == RUN);
    assign done       = (state == DONE);

`ifdef SEQ_DETECT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT+1);
    logic [TW-1:0] idle_cnt;

    assign timeout_hit = (state == RUN) && x_valid && !z && (idle_cnt == TW'(TIMEOUT-1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= timeout_hit;
            if (arm || z) begin
                idle_cnt <= '0;
            end else if ((state == RUN) && x_valid) begin
                idle_cnt <= idle_cnt + TW'(1);
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // start outranks stop outside RUN; inside RUN stop outranks reaching the target.
    always_comb begin
        state_nxt   = state;
        arm         = 1'b0;
        cfg_load    = 1'b0;
        cfg_err_nxt = 1'b0;
        case (state)
            IDLE, DONE: begin
                cfg_load = cfg_wr;
                if (start && len_ok) begin
                    arm       = 1'b1;
                    state_nxt = RUN;
                end else begin
                    cfg_err_nxt = start;
                    if (stop) begin
                        state_nxt = IDLE;
                    end
                end
            end
            RUN: begin
                cfg_err_nxt = cfg_wr;
                if (stop || timeout_hit) begin
                    state_nxt = IDLE;
                end else if (z && target_hit) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            cfg_err <= cfg_err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pattern_q <= MAX_LEN'(4'b1100);
            len_q     <= LW'(4);
            overlap_q <= 1'b0;
            target_q  <= '0;
            history   <= '0;
            fill      <= '0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else begin
            if (cfg_load) begin
                pattern_q <= cfg_pattern;
                len_q     <= cfg_len;
                overlap_q <= cfg_overlap;
                target_q  <= cfg_target;
            end
            if (arm) begin
                history   <= '0;
                fill      <= '0;
                match_cnt <= '0;
                cnt_sat   <= 1'b0;
            end else if ((state == RUN) && x_valid) begin
                history <= window[MAX_LEN-2:0];
                // Non-overlapping mode restarts the fill so old history cannot complete a match.
                if (z && !overlap_q) begin
                    fill <= '0;
                end else if (fill != FILL_MAX) begin
                    fill <= fill + FW'(1);
                end
                if (z) begin
                    match_cnt <= cnt_inc;
                    cnt_sat   <= &cnt_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: default instance plus a CNT_W=2, TIMEOUT=4 instance for saturation/timeout.
module tb_seq_detect_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_wr;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic [7:0] cfg_target;
    logic       start;
    logic       stop;
    logic       x;
    logic       x_valid;

    logic       z, busy, done, cnt_sat, cfg_err;
    logic [7:0] match_cnt;
    logic       s_z, s_busy, s_done, s_cnt_sat, s_cfg_err;
    logic [1:0] s_match_cnt;
`ifdef SEQ_DETECT_TIMEOUT_EN
    logic       d_timeout, s_timeout;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_s    = 1'b0;

    always #5 clk = ~clk;

    seq_detect_ctrl u_dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cfg_target(cfg_target), .start(start), .stop(stop),
        .x(x), .x_valid(x_valid), .z(z), .busy(busy), .done(done), .match_cnt(match_cnt),
        .cnt_sat(cnt_sat), .cfg_err(cfg_err)
`ifdef SEQ_DETECT_TIMEOUT_EN
        , .timeout(d_timeout)
`endif
    );

    seq_detect_ctrl #(.MAX_LEN(8), .CNT_W(2), .TIMEOUT(4)) u_sat (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cfg_target(cfg_target[1:0]), .start(start), .stop(stop),
        .x(x), .x_valid(x_valid), .z(s_z), .busy(s_busy), .done(s_done), .match_cnt(s_match_cnt),
        .cnt_sat(s_cnt_sat), .cfg_err(s_cfg_err)
`ifdef SEQ_DETECT_TIMEOUT_EN
        , .timeout(s_timeout)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ov, input logic [7:0] tgt);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        cfg_target  = tgt;
        cfg_wr      = 1'b1;
        tick();
        cfg_wr      = 1'b0;
    endtask

    // z is Mealy, so it is sampled mid-cycle with the bit applied, before the edge.
    task automatic send(input logic b, input logic exp_z, input string tag);
        x       = b;
        x_valid = 1'b1;
        #2;
        check(tag, z, exp_z);
        if (chk_s) check({tag, "_s"}, s_z, exp_z);
        tick();
        x_valid = 1'b0;
    endtask

    // bits/zm are listed first-bit-first from index n-1 down to 0.
    task automatic send_stream(input logic [31:0] bits, input int n, input logic [31:0] zm, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            send(bits[i], zm[i], $sformatf("%s_z%0d", tag, n - i));
        end
    endtask

    initial begin
        rst = 1'b0; cfg_wr = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        cfg_target = '0; start = 1'b0; stop = 1'b0; x = 1'b0; x_valid = 1'b0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt", match_cnt, 0);
        check("rst_sat", cnt_sat, 0);
        check("rst_err", cfg_err, 0);
        rst = 1'b1;
        tick();

        // Default pattern 1100, non-overlapping.
        do_start();
        check("t1_busy0", busy, 1);
        send_stream(32'b11001101100110010, 17, 32'b00010000001000100, "t1");
        check("t1_cnt", match_cnt, 3);
        check("t1_busy", busy, 1);
        check("t1_done", done, 0);
        do_stop();
        check("t1_stop_busy", busy, 0);
        check("t1_hold_cnt", match_cnt, 3);

        do_cfg(8'b101, 4'd3, 1'b1, 8'd0);
        do_start();
        check("t2_clr_cnt", match_cnt, 0);
        send_stream(32'b10101, 5, 32'b00101, "t2ov");
        check("t2ov_cnt", match_cnt, 2);
        do_stop();
        do_cfg(8'b101, 4'd3, 1'b0, 8'd0);
        do_start();
        send_stream(32'b10101, 5, 32'b00100, "t2no");
        check("t2no_cnt", match_cnt, 1);
        do_stop();

        do_cfg(8'b1100, 4'd4, 1'b0, 8'd2);
        do_start();
        send_stream(32'b110011001100, 12, 32'b000100010000, "t3");
        check("t3_done", done, 1);
        check("t3_busy", busy, 0);
        check("t3_cnt", match_cnt, 2);
        do_stop();
        check("t3_stop_done", done, 0);

        do_cfg(8'b1100, 4'd1, 1'b0, 8'd0);
        do_start();
        check("t4_err", cfg_err, 1);
        check("t4_idle", busy, 0);
        tick();
        check("t4_err_pulse", cfg_err, 0);
        do_cfg(8'b1100, 4'd4, 1'b0, 8'd0);
        do_start();
        check("t4_busy", busy, 1);
        do_cfg(8'b101, 4'd3, 1'b1, 8'd0);
        check("t4_run_err", cfg_err, 1);
        send_stream(32'b1100, 4, 32'b0001, "t4pat");
        check("t4_cnt", match_cnt, 1);
        do_stop();

        do_start();
        send_stream(32'b1100110, 7, 32'b0001000, "t5");
        rst     = 1'b0;
        x       = 1'b0;
        x_valid = 1'b1;
        #2;
        check("t5_rst_z", z, 0);
        tick();
        rst     = 1'b1;
        x_valid = 1'b0;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_cnt", match_cnt, 0);
        do_start();
        send(1'b0, 1'b0, "t5_after_z");
        check("t5_after_cnt", match_cnt, 0);
        send_stream(32'b110, 3, 32'b000, "t5b");
        x       = 1'b0;
        x_valid = 1'b1;
        stop    = 1'b1;
        #2;
        check("t5_stop_z", z, 1);
        tick();
        stop    = 1'b0;
        x_valid = 1'b0;
        check("t5_stop_busy", busy, 0);
        check("t5_stop_done", done, 0);
        check("t5_stop_cnt", match_cnt, 1);

        // Saturation on the 2-bit counter instance.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        do_cfg(8'b10, 4'd2, 1'b1, 8'd0);
        do_start();
        chk_s = 1'b1;
        send_stream(32'b1010, 4, 32'b0101, "t6a");
        check("t6_cnt2", s_match_cnt, 2);
        check("t6_sat0", s_cnt_sat, 0);
        send_stream(32'b101010, 6, 32'b010101, "t6b");
        check("t6_cnt_sat", s_match_cnt, 3);
        check("t6_sat1", s_cnt_sat, 1);
        check("t6_busy", s_busy, 1);
        check("t6_done", s_done, 0);
        check("t6_wide_cnt", match_cnt, 5);
        check("t6_err", s_cfg_err, 0);

`ifdef SEQ_DETECT_TIMEOUT_EN
        do_stop();
        do_start();
        send_stream(32'b000, 3, 32'b000, "t7");
        check("t7_busy3", s_busy, 1);
        check("t7_to3", s_timeout, 0);
        send(1'b0, 1'b0, "t7_z4");
        check("t7_to", s_timeout, 1);
        check("t7_busy", s_busy, 0);
        check("t7_dut_to", d_timeout, 0);
        tick();
        check("t7_to_pulse", s_timeout, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Run-time controller for the serial Mealy pattern detector path.
- Holds a programmable pattern (default 1100), length, overlap mode and match target.
- Sequences arm/run/done operation and counts detections.
- Sits between the control/config interface and the serial bit stream x, and produces the Mealy detect pulse z.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (legal range 2..16).
- CNT_W, 8: width of the match counter and the target register.
- TIMEOUT, 64: bit-valid cycles without a match before abort (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset (rst=0 at a clk edge resets the block).
- cfg_wr  in  1  configuration write strobe.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received.
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_target  in  CNT_W  match count that ends the run; 0 = unlimited.
- start  in  1  arm pulse.
- stop  in  1  abort pulse.
- x  in  1  serial data bit.
- x_valid  in  1  x is sampled this cycle.
- z  out  1  Mealy detect: combinational, high in the cycle the last pattern bit is present.
- busy  out  1  state is RUN.
- done  out  1  state is DONE.
- match_cnt  out  CNT_W  matches since last start; saturating.
- cnt_sat  out  1  match_cnt has reached its all-ones value.
- cfg_err  out  1  one-cycle pulse on an illegal config or start request.

Behaviour:
- Reset (rst=0): state IDLE; pattern=4'b1100 zero-extended; len=4; overlap=0; target=0; history=0; fill=0; match_cnt=0; busy, done, cnt_sat, cfg_err = 0. z is forced to 0 while rst=0.
- States:
  - IDLE -> RUN on start, provided the stored len is in 2..MAX_LEN. This clears match_cnt, fill, history and cnt_sat. If len is illegal, stay in IDLE and pulse cfg_err.
  - RUN -> IDLE on stop. match_cnt is held.
  - RUN -> DONE at the edge where a match makes match_cnt equal a non-zero target.
  - DONE -> RUN on start (same clears as IDLE->RUN). DONE -> IDLE on stop.
- cfg_wr is accepted only in IDLE or DONE; it loads all cfg_* inputs the next edge. cfg_wr in RUN is ignored and pulses cfg_err.
- Detection applies only in RUN with x_valid=1:
  - z = (fill >= len-1) && ({history[len-2:0], x} == pattern[len-1:0]).
  - On x_valid, history shifts left taking x, and fill increments, saturating at MAX_LEN-1.
  - On z with overlap=0: fill is cleared to 0 and history is kept but ignored.
  - On z with overlap=1: fill is kept.
  - x_valid=0: no shift and z=0.
- match_cnt increments on every z, saturating at 2^CNT_W-1. cnt_sat is set at saturation.
- Latency: z is zero-cycle (Mealy). match_cnt, done and busy update one edge after the causing event.
- Simultaneous events:
  - start with stop in IDLE/DONE: start wins.
  - stop with a match in RUN: the match is counted, z still pulses and state goes to IDLE (stop beats DONE).
  - start in RUN is ignored.
  - cfg_wr with start in IDLE: start uses the old config and the new config loads the same edge; the cfg_err check uses the old len.
- Reset mid-run: immediate return to reset values at that edge. No partial match survives.

Optional Feature:
- Macro SEQ_DETECT_TIMEOUT_EN.
- Defined:
  - Adds output port timeout (1 bit) and a $clog2(TIMEOUT+1)-bit idle counter.
  - The counter counts x_valid cycles in RUN since start or the last match.
  - On reaching TIMEOUT with no match that cycle: RUN -> IDLE and a one-cycle timeout pulse.
  - The counter clears on any z.
- Undefined: no timeout port, no counter, and RUN persists indefinitely.

Test Plan:
- Reset defaults, then start with no cfg_wr; stream 1,1,0,0,1,1,0,1,1,0,0,1,1,0,0,1,0 (x_valid=1). Expect z high on bits 4, 11 and 15; match_cnt=3; busy=1.
- cfg pattern=101, len=3, overlap=1; stream 1,0,1,0,1. Expect z on bits 3 and 5, match_cnt=2. Repeat with overlap=0: z on bit 3 only, match_cnt=1.
- cfg_target=2 with pattern 1100; stream 1,1,0,0,1,1,0,0,1,1,0,0. Expect DONE after the 8th bit, done=1, busy=0, match_cnt=2, and no z on bits 9-12.
- cfg_len=1, then start: cfg_err pulses for one cycle and the state stays IDLE. cfg_wr during RUN: cfg_err pulses and pattern is unchanged.
- Drive rst=0 for one cycle after bits 1,1,0 of 1100, then restart and send 0: z=0 and match_cnt=0. Also drive stop in the same cycle as a matching bit: z=1, match_cnt increments, next state IDLE.
- CNT_W=2 with pattern 10, overlap=1; feed 5 matches. Expect match_cnt saturates at 3 and cnt_sat=1. With SEQ_DETECT_TIMEOUT_EN and TIMEOUT=4, feed four 0s: timeout pulses and busy drops.
